// File: rtl/gate_unit_arbiter_if.sv
// gate_unit_arbiter_if: request/response bundle between NREQ requesters and the shared gate unit.
interface gate_unit_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [WIDTH*NREQ-1:0] req_A, req_B;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_y;
  logic [IDW-1:0] rsp_id;
  modport master(output req_valid, req_op, req_A, req_B, rsp_ready,
                 input req_ready, rsp_valid, rsp_y, rsp_id, rsp_err);
  modport slave(input req_valid, req_op, req_A, req_B, rsp_ready,
                output req_ready, rsp_valid, rsp_y, rsp_id, rsp_err);
endinterface

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin shared 7-function gate unit with registered response.
// Optional GATE_ARB_PERF_EN adds saturating grant_count/illegal_count outputs.
module gate_unit_arbiter #(parameter int NREQ = 4, parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  gate_unit_arbiter_if.slave bus
`ifdef GATE_ARB_PERF_EN
  ,
  output logic [15:0] grant_count,
  output logic [7:0] illegal_count
`endif
);
  localparam int IDW = $clog2(NREQ);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q;
  logic [IDW-1:0] rr_q, rr_d, gnt, idx, id_q;
  logic found, xfer, err_d, err_q, valid_q;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, y_d, y_q;
  logic [2:0] op_a [NREQ];
  logic [WIDTH-1:0] a_a [NREQ];
  logic [WIDTH-1:0] b_a [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign op_a[i] = bus.req_op[3*i +: 3];
    assign a_a[i] = bus.req_A[WIDTH*i +: WIDTH];
    assign b_a[i] = bus.req_B[WIDTH*i +: WIDTH];
  end
  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_q) + k) % NREQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign xfer = (state_q == IDLE) && found;
  assign rr_d = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
  assign op = op_a[gnt];
  assign a = a_a[gnt];
  assign b = b_a[gnt];
  assign err_d = (op == 3'd7);
  always_comb begin
    y_d = (op == 3'd0) ? (a & b) :
          (op == 3'd1) ? (a | b) :
          (op == 3'd2) ? ~a :
          (op == 3'd3) ? ~(a & b) :
          (op == 3'd4) ? ~(a | b) :
          (op == 3'd5) ? (a ^ b) :
          (op == 3'd6) ? ~(a ^ b) : '0;
  end
  assign bus.req_ready = xfer ? (NREQ'(1) << gnt) : '0;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_y = y_q;
  assign bus.rsp_id = id_q;
  assign bus.rsp_err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      valid_q <= 1'b0;
      y_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
    end else if (xfer) begin
      y_q <= y_d;
      err_q <= err_d;
      id_q <= gnt;
      valid_q <= 1'b1;
      rr_q <= rr_d;
      state_q <= RESP;
    end else if (state_q == RESP && bus.rsp_ready) begin
      valid_q <= 1'b0;
      state_q <= IDLE;
    end
  end
`ifdef GATE_ARB_PERF_EN
  logic [15:0] gcnt_q;
  logic [7:0] icnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
      icnt_q <= '0;
    end else if (xfer) begin
      if (gcnt_q != '1) gcnt_q <= gcnt_q + 1'b1;
      if (err_d && icnt_q != '1) icnt_q <= icnt_q + 1'b1;
    end
  end
  assign grant_count = gcnt_q;
  assign illegal_count = icnt_q;
`endif
endmodule
